t02_mem_arbiter: RTL
====================

// Module: t02_mem_arbiter
// PURPOSE
// Sequences the single shared RAM port between instruction fetch and data load/store.
// Sits between t02_pc/t02_control and the external RAM (ramaddr/ramstore/ramload/busy_o).
// Grants one requester at a time, drives a one-cycle Ren/Wen strobe, waits out busy_o,
// then returns read data with a one-cycle ready pulse. Has a timeout watchdog and starvation guard.
// PARAMETERS
// TIMEOUT_CYC  256  WAIT cycles before abandoning an access (counter width = clog2+1)
// MAX_D_STREAK 4    consecutive data grants while fetch pends before fetch is forced
// PORTS
// clk         in   1   system clock, all state on posedge
// rst         in   1   asynchronous reset, active-high
// enable      in   1   0 = no new grants; an in-flight access still completes
// i_req       in   1   fetch request, held until i_ready
// i_addr      in   32  fetch address (PC)
// d_ren       in   1   data read request, held until d_ready
// d_wen       in   1   data write request, held until d_ready (d_ren&d_wen -> write)
// d_addr      in   32  data address (ALU result)
// d_wdata     in   32  store data
// i_rdata     out  32  fetched instruction, valid with i_ready, held after
// i_ready     out  1   one-cycle fetch-complete pulse
// d_rdata     out  32  load data, valid with d_ready, held after
// d_ready     out  1   one-cycle data-complete pulse
// ramaddr     out  32  RAM word address
// ramstore    out  32  RAM write data
// ramload     in   32  RAM read data, valid when busy_o low in WAIT
// Ren         out  1   RAM read strobe
// Wen         out  1   RAM write strobe
// busy_o      in   1   RAM busy
// timeout_err out  1   sticky: some access hit TIMEOUT_CYC
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, streak 0, timeout counter 0; async, also mid-access.
// States IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
// IDLE: if enable and a request: pick winner, latch op/addr/wdata -> ISSUE; else stay.
//  Priority: data over fetch; but if streak==MAX_D_STREAK and i_req, grant fetch.
//  streak++ on data grant while i_req high; cleared on fetch grant or when i_req low.
// ISSUE (1 cycle): ramaddr={addr[31:2],2'b00}; ramstore=wdata on write else 0;
//  Ren=1 for read/fetch, Wen=1 for write, never both. -> WAIT; counter cleared.
// WAIT: Ren=Wen=0, ramaddr/ramstore held. busy_o ignored in the first WAIT cycle
//  (RAM raises it one cycle after strobe). From the 2nd WAIT cycle, busy_o==0 -> capture
//  ramload into i_rdata (fetch) or d_rdata (read); -> RESP. Write: rdata unchanged.
//  Counter counts WAIT cycles; reaching TIMEOUT_CYC -> RESP, set timeout_err, rdata
//  captured as 32'h0000_0013 for fetch (NOP), 32'h0 for read.
// RESP (1 cycle): pulse i_ready or d_ready for the granted requester only -> IDLE.
// Minimum latency: request seen in IDLE cycle N -> ready high in cycle N+4.
// Requester may change address/request in the cycle after ready; IDLE re-arbitrates.
// Request dropped mid-access: access still completes; ready pulse still issued.
// enable falling mid-access: no effect until return to IDLE.
// timeout_err cleared only by rst.
// TESTING
// Fetch only, i_addr=0x33000004, busy_o high 3 cycles then low, ramload=0x00A00093
//  -> one Ren pulse, ramaddr=0x33000004, i_rdata=0x00A00093, i_ready 1 cycle, Wen never 1.
// i_req and d_wen together, d_addr=0x3300_0102, d_wdata=0xCAFEF00D -> write first,
//  ramaddr=0x33000100, Wen pulse; d_ready, then fetch granted next.
// d_ren held continuously with i_req, MAX_D_STREAK=4 -> 4 data grants then 1 fetch grant.
// busy_o stuck high, TIMEOUT_CYC=8 -> after 8 WAIT cycles i_ready with i_rdata=0x00000013,
//  timeout_err=1 and stays 1.
// rst asserted during WAIT -> Ren/Wen/ready/timeout_err 0 same cycle, state IDLE;
//  after release a held request restarts from ISSUE.
// enable=0 with i_req=1 -> no Ren for 10 cycles; enable=1 -> Ren pulse next-but-one cycle.

Source files
------------

// File: rtl/t02_mem_arbiter_if.sv
// Request, response and RAM-side signal bundle for the shared RAM port arbiter.
// slave is the arbiter's view; master is the requester/RAM environment's view.
interface t02_mem_arbiter_if;
    logic        enable;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        Ren;
    logic        Wen;
    logic        busy_o;
    logic        timeout_err;

    modport slave (
        input  enable, i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ramload, busy_o,
        output i_rdata, i_ready, d_rdata, d_ready, ramaddr, ramstore, Ren, Wen, timeout_err
    );

    modport master (
        output enable, i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ramload, busy_o,
        input  i_rdata, i_ready, d_rdata, d_ready, ramaddr, ramstore, Ren, Wen, timeout_err
    );
endinterface

// File: rtl/t02_mem_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store: IDLE -> ISSUE -> WAIT -> RESP,
// with a WAIT-cycle timeout watchdog and a cap on consecutive data grants while fetch waits.
module t02_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC  = 256,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    t02_mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned STK_W = $clog2(MAX_D_STREAK + 1) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

    logic [1:0]       r_state, w_state;
    logic             r_is_fetch, w_is_fetch;
    logic             r_is_write, w_is_write;
    logic [STK_W-1:0] r_streak, w_streak;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [31:0]      r_ramaddr, w_ramaddr;
    logic [31:0]      r_ramstore, w_ramstore;
    logic [31:0]      r_i_rdata, w_i_rdata;
    logic [31:0]      r_d_rdata, w_d_rdata;
    logic             r_ren, w_ren;
    logic             r_wen, w_wen;
    logic             r_i_ready, w_i_ready;
    logic             r_d_ready, w_d_ready;
    logic             r_timeout_err, w_timeout_err;

    logic             w_d_req;
    logic             w_fetch_win;
    logic             w_grant;
    logic             w_wr_sel;
    logic [31:0]      w_sel_addr;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_busy_valid;
    logic             w_done;
    logic             w_expire;

    assign w_d_req     = bus.d_ren | bus.d_wen;
    assign w_fetch_win = bus.i_req & (~w_d_req | (r_streak == STK_W'(MAX_D_STREAK)));
    assign w_grant     = (r_state == ST_IDLE) & bus.enable & (bus.i_req | w_d_req);
    assign w_wr_sel    = ~w_fetch_win & bus.d_wen;
    assign w_sel_addr  = w_fetch_win ? bus.i_addr : bus.d_addr;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // The RAM raises busy_o one cycle after the strobe, so the first WAIT cycle cannot complete.
    assign w_busy_valid = (r_cnt != '0);
    assign w_done       = (r_state == ST_WAIT) & w_busy_valid & ~bus.busy_o;
    assign w_expire     = (r_state == ST_WAIT) & ~w_done & (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        w_state       = r_state;
        w_is_fetch    = r_is_fetch;
        w_is_write    = r_is_write;
        w_streak      = r_streak;
        w_cnt         = r_cnt;
        w_ramaddr     = r_ramaddr;
        w_ramstore    = r_ramstore;
        w_i_rdata     = r_i_rdata;
        w_d_rdata     = r_d_rdata;
        w_timeout_err = r_timeout_err;
        w_ren         = 1'b0;
        w_wen         = 1'b0;
        w_i_ready     = 1'b0;
        w_d_ready     = 1'b0;

        // Streak only measures data grants taken while fetch is actually waiting.
        if (!bus.i_req) begin
            w_streak = '0;
        end else if (w_grant) begin
            w_streak = w_fetch_win ? '0 : r_streak + STK_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state    = ST_ISSUE;
                    w_is_fetch = w_fetch_win;
                    w_is_write = w_wr_sel;
                    w_ramaddr  = {w_sel_addr[31:2], 2'b00};
                    w_ramstore = w_wr_sel ? bus.d_wdata : 32'h0;
                    w_ren      = ~w_wr_sel;
                    w_wen      = w_wr_sel;
                    w_cnt      = '0;
                end
            end
            ST_ISSUE: begin
                w_state = ST_WAIT;
                w_cnt   = '0;
            end
            ST_WAIT: begin
                w_cnt = w_cnt_inc;
                if (w_done || w_expire) begin
                    w_state   = ST_RESP;
                    w_i_ready = r_is_fetch;
                    w_d_ready = ~r_is_fetch;
                    if (w_expire) begin
                        w_timeout_err = 1'b1;
                    end
                    if (r_is_fetch) begin
                        w_i_rdata = w_done ? bus.ramload : FETCH_NOP;
                    end else if (!r_is_write) begin
                        w_d_rdata = w_done ? bus.ramload : 32'h0;
                    end
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_is_fetch    <= 1'b0;
            r_is_write    <= 1'b0;
            r_streak      <= '0;
            r_cnt         <= '0;
            r_ramaddr     <= 32'h0;
            r_ramstore    <= 32'h0;
            r_i_rdata     <= 32'h0;
            r_d_rdata     <= 32'h0;
            r_ren         <= 1'b0;
            r_wen         <= 1'b0;
            r_i_ready     <= 1'b0;
            r_d_ready     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_is_fetch    <= w_is_fetch;
            r_is_write    <= w_is_write;
            r_streak      <= w_streak;
            r_cnt         <= w_cnt;
            r_ramaddr     <= w_ramaddr;
            r_ramstore    <= w_ramstore;
            r_i_rdata     <= w_i_rdata;
            r_d_rdata     <= w_d_rdata;
            r_ren         <= w_ren;
            r_wen         <= w_wen;
            r_i_ready     <= w_i_ready;
            r_d_ready     <= w_d_ready;
            r_timeout_err <= w_timeout_err;
        end
    end

    assign bus.ramaddr     = r_ramaddr;
    assign bus.ramstore    = r_ramstore;
    assign bus.Ren         = r_ren;
    assign bus.Wen         = r_wen;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.i_ready     = r_i_ready;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.d_ready     = r_d_ready;
    assign bus.timeout_err = r_timeout_err;
endmodule
